serial_word_rx: RTL and testbench

//   Receiving end of the team's LSB-first bit-serial datapath. Accepts a framed

---
 rtl/serial_word_rx.sv | 197 +++++++++++++++++++
 tb/tb_serial_word_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// serial_word_rx
//   LSB-first bit-serial word receiver. A framed serial stream (start marks
//   bit 0) is deserialised into WIDTH-bit words and presented on a
//   valid/ready output backed by a single holding register.
//
//   Overrun: a word that completes while the held word is unconsumed and
//   out_ready is low is dropped, and overrun pulses.
//
//   Framing error: a start that arrives mid-word discards the partial word,
//   restarts the frame on that bit, and pulses frame_err.
//
//   Optional feature, enabled by defining the macro MIN_DETECT_EN:
//   adds the registered is_min output. It flags the most-negative 2's
//   complement word, {1'b1, {WIDTH-1{1'b0}}}. The default build leaves it out.
//
//   Reset is synchronous and active-low (reset = 0 at posedge clk).

module serial_word_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             start,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             frame_err
`ifdef MIN_DETECT_EN
  ,
  output logic             is_min
`endif
);

  // Bit counter only needs to reach WIDTH-1.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Frame tracking state
  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [WIDTH-1:0]  shift_q;
  logic [WIDTH-1:0]  shift_d;

  // Output holding register and status pulses
  logic [WIDTH-1:0]  word_q;
  logic [WIDTH-1:0]  word_d;
  logic              valid_q;
  logic              valid_d;
  logic              overrun_q;
  logic              overrun_d;
  logic              frame_err_q;
  logic              frame_err_d;
`ifdef MIN_DETECT_EN
  logic              is_min_q;
  logic              is_min_d;
`endif

  // Events decoded by the next-state logic, consumed by the output logic
  logic              word_done_s;
  logic              restart_s;
  logic [WIDTH-1:0]  done_word_s;

  // Returns 1 when w is the most-negative 2's complement value.
  function automatic logic is_min_word(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] min_v;
    min_v = {1'b1, {(WIDTH-1){1'b0}}};
    return (w == min_v);
  endfunction

  // Shift right so that the first accepted bit lands at index 0 once
  // WIDTH bits are in. The last bit enters at the MSB.
  assign done_word_s = {in, shift_q[WIDTH-1:1]};

  // State register: every flop, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= ZERO_CNT;
      shift_q     <= {WIDTH{1'b0}};
      word_q      <= {WIDTH{1'b0}};
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef MIN_DETECT_EN
      is_min_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef MIN_DETECT_EN
      is_min_q    <= is_min_d;
`endif
    end
  end

  // Next-state logic: frame sequencing, bit counting and shifting.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    word_done_s = 1'b0;
    restart_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && start) begin
          // Bit 0 of a new frame
          state_d = ST_SHIFT;
          count_d = ONE_CNT;
          shift_d = {in, {(WIDTH-1){1'b0}}};
        end else begin
          // Idle line or stray bits outside a frame: discard
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!in_valid) begin
          // Gap in the stream: hold everything, no timeout
          state_d = ST_SHIFT;
        end else if (start) begin
          // Start mid-word: drop the partial word and restart on this bit
          restart_s = 1'b1;
          state_d   = ST_SHIFT;
          count_d   = ONE_CNT;
          shift_d   = {in, {(WIDTH-1){1'b0}}};
        end else if (count_q == LAST_CNT) begin
          // Final bit: word is complete
          word_done_s = 1'b1;
          state_d     = ST_IDLE;
          count_d     = ZERO_CNT;
          shift_d     = {WIDTH{1'b0}};
        end else begin
          // Ordinary data bit
          state_d = ST_SHIFT;
          count_d = count_q + ONE_CNT;
          shift_d = done_word_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = ZERO_CNT;
        shift_d = {WIDTH{1'b0}};
      end
    endcase
  end

  // Output logic: holding register, handshake and status pulses.
  always_comb begin
    word_d      = word_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = restart_s;
`ifdef MIN_DETECT_EN
    is_min_d    = is_min_q;
`endif
    if (word_done_s && (!valid_q || out_ready)) begin
      // Holding register is free (or being consumed this edge): load
      word_d  = done_word_s;
      valid_d = 1'b1;
`ifdef MIN_DETECT_EN
      is_min_d = is_min_word(done_word_s);
`endif
    end else if (word_done_s) begin
      // Held word not consumed: the new word is lost
      overrun_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign out_word  = word_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
`ifdef MIN_DETECT_EN
  assign is_min    = is_min_q;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Testbench for serial_word_rx (WIDTH = 8).
// Directed scenarios, then a randomized stream. A queue-based frame model
// is compared against the DUT on every falling edge.
module tb_serial_word_rx;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in;
  logic         in_valid;
  logic         start;
  logic [W-1:0] out_word;
  logic         out_valid;
  logic         out_ready;
  logic         overrun;
  logic         frame_err;
`ifdef MIN_DETECT_EN
  logic         is_min;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_word_rx #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .start     (start),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .frame_err (frame_err)
`ifdef MIN_DETECT_EN
    ,
    .is_min    (is_min)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: accepted bits of the open frame are kept in a queue.
  bit           chk_en = 1'b0;
  bit           m_in_frame = 1'b0;
  bit           m_bits[$];
  logic [W-1:0] m_word = '0;
  bit           m_valid = 1'b0;
  bit           m_ovr = 1'b0;
  bit           m_ferr = 1'b0;
  bit           m_min = 1'b0;

  always @(posedge clk) begin
    bit           done;
    logic [W-1:0] w;
    if (!reset) begin
      chk_en     = 1'b1;
      m_in_frame = 1'b0;
      m_bits.delete();
      m_word = '0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_min = 1'b0;
    end else begin
      done   = 1'b0;
      w      = '0;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      if (in_valid) begin
        if (start) begin
          if (m_in_frame) m_ferr = 1'b1;
          m_bits.delete();
          m_bits.push_back(in);
          m_in_frame = 1'b1;
        end else if (m_in_frame) begin
          m_bits.push_back(in);
        end
        if (m_in_frame && m_bits.size() == W) begin
          for (int i = 0; i < W; i++) w[i] = m_bits[i];
          done = 1'b1;
          m_in_frame = 1'b0;
          m_bits.delete();
        end
      end
      if (done) begin
        if (!m_valid || out_ready) begin
          m_word  = w;
          m_valid = 1'b1;
          m_min   = (w == 8'h80);
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out_word", 32'(out_word), 32'(m_word));
      check("model_out_valid", 32'(out_valid), 32'(m_valid));
      check("model_overrun", 32'(overrun), 32'(m_ovr));
      check("model_frame_err", 32'(frame_err), 32'(m_ferr));
`ifdef MIN_DETECT_EN
      if (m_valid) check("model_is_min", 32'(is_min), 32'(m_min));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one 8-bit frame LSB first, with optional random in_valid gaps.
  task automatic send_word(input logic [7:0] w, input int maxgap, input bit ferr_chk);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in       = w[i];
      start    = (i == 0);
      tick();
      if (i == 0 && ferr_chk) check("frame_err_pulse", 32'(frame_err), 32'd1);
      in_valid = 1'b0;
      start    = 1'b0;
      in       = 1'($urandom_range(0, 1));
      if (i != 7 && maxgap > 0) repeat ($urandom_range(1, maxgap)) tick();
    end
  endtask

  initial begin
    reset = 1'b0; in = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // 1. Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      in = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("rst_out_word", 32'(out_word), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b1; in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    tick();

    // 2. Back-to-back 0xA5 frame
    send_word(8'hA5, 0, 1'b0);
    check("a5_word", 32'(out_word), 32'hA5);
    check("a5_valid", 32'(out_valid), 32'd1);
    tick();
    check("a5_valid_one_cycle", 32'(out_valid), 32'd0);

    // 3. Same frame with idle gaps
    send_word(8'hA5, 3, 1'b0);
    check("a5gap_word", 32'(out_word), 32'hA5);
    check("a5gap_valid", 32'(out_valid), 32'd1);
    tick();
    check("a5gap_valid_drop", 32'(out_valid), 32'd0);

    // 4. Overrun with a stalled consumer
    out_ready = 1'b0;
    send_word(8'h3C, 0, 1'b0);
    check("ovr_first_word", 32'(out_word), 32'h3C);
    check("ovr_first_valid", 32'(out_valid), 32'd1);
    send_word(8'h81, 0, 1'b0);
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_word_kept", 32'(out_word), 32'h3C);
    check("ovr_valid_kept", 32'(out_valid), 32'd1);
    tick();
    check("ovr_pulse_end", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    tick();
    check("ovr_consumed", 32'(out_valid), 32'd0);

    // 5a. Start mid-word
    in_valid = 1'b1; start = 1'b1; in = 1'b1; tick();
    start = 1'b0; in = 1'b0; tick();
    in = 1'b1; tick();
    in_valid = 1'b0;
    send_word(8'h01, 0, 1'b1);
    check("ferr_word", 32'(out_word), 32'h01);
    check("ferr_valid", 32'(out_valid), 32'd1);
    tick();

    // 5b. Reset mid-word
    in_valid = 1'b1; start = 1'b1; in = 1'b1; tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin in = 1'($urandom_range(0, 1)); tick(); end
    in_valid = 1'b0; reset = 1'b0; tick();
    reset = 1'b1;
    in_valid = 1'b1; start = 1'b0; in = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    check("rstmid_no_word", 32'(out_valid), 32'd0);
    send_word(8'h5A, 2, 1'b0);
    check("rstmid_next_word", 32'(out_word), 32'h5A);
    check("rstmid_next_valid", 32'(out_valid), 32'd1);
    tick();

`ifdef MIN_DETECT_EN
    // 6. Most-negative detection
    send_word(8'h80, 0, 1'b0);
    check("min_80", 32'(is_min), 32'd1);
    tick();
    send_word(8'h7F, 0, 1'b0);
    check("min_7f", 32'(is_min), 32'd0);
    tick();
`endif

    // Randomized stream against the model
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      start     = ($urandom_range(0, 11) == 0);
      in        = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
